// File: rtl/ex_operand_mux_pipe.sv
// ----------------------------------------------------------------------------
// ex_operand_mux_pipe
//   N-way ALU operand select for the Execute stage. It has a registered output
//   stage and a one-entry skid slot, so the block buffers up to two entries in
//   total. Both sides use a valid/ready handshake. in_ready is a flop, so a
//   stall from the ALU never reaches upstream combinationally.
//
//   Optional feature macro: EX_OPMUX_PARITY_EN
//     When defined, the y_par port exists and carries the even parity of y.
//     The skid slot keeps its own parity bit.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous flush; drops everything held in the block
//   in_valid   in   upstream presents src_flat + sel
//   in_ready   out  block accepts this cycle (registered)
//   src_flat   in   source k at bits [k*WIDTH +: WIDTH]
//   sel        in   source index
//   out_valid  out  y is valid to the ALU
//   out_ready  in   ALU consumes y this cycle
//   y          out  selected operand (0 for an out-of-range sel)
//   sel_err    out  the entry in y had sel >= NUM_SRC
//   y_par      out  even parity of y (EX_OPMUX_PARITY_EN only)
// ----------------------------------------------------------------------------
module ex_operand_mux_pipe #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SRC*WIDTH-1:0] src_flat,
    input  logic [SEL_W-1:0]         sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         y,
    output logic                     sel_err
`ifdef EX_OPMUX_PARITY_EN
    ,
    output logic                     y_par
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   y_reg;
    logic               sel_err_reg;
    logic [WIDTH-1:0]   skid_y_reg;
    logic               skid_err_reg;

    logic [NUM_SRC-1:0] hit;
    logic [WIDTH-1:0]   mux_y;
    logic               mux_err;
    logic               accept;
    logic               pop;

    // One-hot decode of sel. An out-of-range sel matches nothing.
    // That yields y=0 and sel_err=1 without indexing past the source vector.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_hit
            assign hit[gi] = (sel == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        mux_y = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            mux_y = mux_y | (src_flat[k*WIDTH +: WIDTH] & {WIDTH{hit[k]}});
        end
        mux_err = ~|hit;
    end

    assign accept = in_valid & in_ready_reg;
    assign pop    = out_valid_reg & out_ready;

    // Occupancy. A flush empties the block whatever else happens that cycle.
    // A pop in the same cycle still completes, because the ALU samples y at this edge.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY:   if (accept) state_next = ONE;
                ONE: begin
                    if (accept && !pop)      state_next = FULL;
                    else if (!accept && pop) state_next = EMPTY;
                end
                FULL:    if (pop) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

`ifdef EX_OPMUX_PARITY_EN
    logic mux_par;
    logic y_par_reg;
    logic skid_par_reg;

    // An error entry has mux_y == 0, so its parity is 0 as well.
    assign mux_par = ^mux_y;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            sel_err_reg   <= 1'b0;
            skid_y_reg    <= '0;
            skid_err_reg  <= 1'b0;
`ifdef EX_OPMUX_PARITY_EN
            y_par_reg     <= 1'b0;
            skid_par_reg  <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next != FULL);
            out_valid_reg <= (state_next != EMPTY);
            if (!flush) begin
                case (state_reg)
                    EMPTY: begin
                        if (accept) begin
                            y_reg       <= mux_y;
                            sel_err_reg <= mux_err;
`ifdef EX_OPMUX_PARITY_EN
                            y_par_reg   <= mux_par;
`endif
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            y_reg       <= mux_y;
                            sel_err_reg <= mux_err;
`ifdef EX_OPMUX_PARITY_EN
                            y_par_reg   <= mux_par;
`endif
                        end else if (accept) begin
                            // Output is stalled, so the new entry parks behind it.
                            skid_y_reg   <= mux_y;
                            skid_err_reg <= mux_err;
`ifdef EX_OPMUX_PARITY_EN
                            skid_par_reg <= mux_par;
`endif
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so only the older skid entry can advance.
                        if (pop) begin
                            y_reg       <= skid_y_reg;
                            sel_err_reg <= skid_err_reg;
`ifdef EX_OPMUX_PARITY_EN
                            y_par_reg   <= skid_par_reg;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign y         = y_reg;
    assign sel_err   = sel_err_reg;
`ifdef EX_OPMUX_PARITY_EN
    assign y_par     = y_par_reg;
`endif

endmodule

// File: tb/tb_ex_operand_mux_pipe.sv
// ----------------------------------------------------------------------------
// tb_ex_operand_mux_pipe
//   Bench for ex_operand_mux_pipe.
//   dut  (NUM_SRC=4): scoreboarded streaming, backpressure, flush and reset
//                     sequences.
//   dut3 (NUM_SRC=3): a table of select vectors covering out-of-range sel and
//                     parity constants.
// ----------------------------------------------------------------------------
module tb_ex_operand_mux_pipe;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- dut: NUM_SRC = 4 ----------------
    logic          flush, in_valid, in_ready, out_valid, out_ready, sel_err;
    logic [4*W-1:0] src_flat;
    logic [1:0]    sel;
    logic [W-1:0]  y;
    logic          y_par;

    // ---------------- dut3: NUM_SRC = 3 ----------------
    logic          flush3, in3_valid, in3_ready, out3_valid, out3_ready, sel3_err;
    logic [3*W-1:0] src3_flat;
    logic [1:0]    sel3;
    logic [W-1:0]  y3;
    logic          y3_par;

    ex_operand_mux_pipe #(.WIDTH(W), .NUM_SRC(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .src_flat(src_flat), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .sel_err(sel_err)
`ifdef EX_OPMUX_PARITY_EN
        , .y_par(y_par)
`endif
    );

    ex_operand_mux_pipe #(.WIDTH(W), .NUM_SRC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush3),
        .in_valid(in3_valid), .in_ready(in3_ready),
        .src_flat(src3_flat), .sel(sel3),
        .out_valid(out3_valid), .out_ready(out3_ready),
        .y(y3), .sel_err(sel3_err)
`ifdef EX_OPMUX_PARITY_EN
        , .y_par(y3_par)
`endif
    );

`ifndef EX_OPMUX_PARITY_EN
    assign y_par  = 1'b0;
    assign y3_par = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard for dut ----------------
    typedef struct packed {
        logic [W-1:0] y;
        logic         err;
        logic         par;
    } sb_t;

    sb_t sb[$];

    // Sampled mid-cycle. A pop is checked before this cycle's accept is queued.
    // A flush drops whatever is still queued, but a pop in the same cycle still counts.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    chk("unexpected_pop", {32'h0, y}, 64'hDEAD);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("pop_y", {32'h0, y}, {32'h0, e.y});
                    chk("pop_err", {63'h0, sel_err}, {63'h0, e.err});
`ifdef EX_OPMUX_PARITY_EN
                    chk("pop_par", {63'h0, y_par}, {63'h0, e.par});
`endif
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb_t n;
                n.y   = src_flat[int'(sel)*W +: W];
                n.err = 1'b0;
                n.par = ^n.y;
                sb.push_back(n);
                $display("push sel=%0d y=%h", sel, n.y);
            end
        end
    end

    // ---------------- table for dut3 ----------------
    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] y;
        logic         err;
        logic         par;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        // Hand-derived: 7 has three set bits, 3 has two, and C000_0002 has three.
        tbl[0] = '{2'd0, 32'h0000_0007, 1'b0, 1'b1};
        tbl[1] = '{2'd1, 32'h0000_0003, 1'b0, 1'b0};
        tbl[2] = '{2'd3, 32'h0000_0000, 1'b1, 1'b0};
        tbl[3] = '{2'd2, 32'hC000_0002, 1'b0, 1'b1};
        tbl[4] = '{2'd0, 32'h0000_0007, 1'b0, 1'b1};
        tbl[5] = '{2'd3, 32'h0000_0000, 1'b1, 1'b0};
        tbl[6] = '{2'd1, 32'h0000_0003, 1'b0, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = '0; src_flat = '0;
        flush3 = 1'b0; in3_valid = 1'b0; out3_ready = 1'b1; sel3 = '0;
        src3_flat = {32'hC000_0002, 32'h0000_0003, 32'h0000_0007};

        // ---- 1. reset ----
        repeat (3) step();
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_y", {32'h0, y}, 64'h0);
        chk("rst_sel_err", {63'h0, sel_err}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_y_par", {63'h0, y_par}, 64'h0);
        chk("rst3_in_ready", {63'h0, in3_ready}, 64'h1);
        rst_n = 1'b1;
        step(); step();
        chk("post_rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("post_rst_in_ready", {63'h0, in_ready}, 64'h1);

        // ---- 2. streaming with out_ready = 1 ----
        src_flat = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
        out_ready = 1'b1;
        p0 = pops;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; sel = 2'(k);
            step();
            chk("stream_out_valid", {63'h0, out_valid}, 64'h1);
            chk("stream_y", {32'h0, y}, {32'h0, 32'h1000_0000 + 32'(k)});
            chk("stream_in_ready", {63'h0, in_ready}, 64'h1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", {63'h0, out_valid}, 64'h0);
        chk("stream_pops", 64'(pops - p0), 64'd4);

        // ---- 3. backpressure fills output + skid ----
        src_flat = {32'h3333_3333, 32'h2222_2222, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        out_ready = 1'b0;
        p0 = pops;
        in_valid = 1'b1; sel = 2'd0; step();
        chk("bp_in_ready_one", {63'h0, in_ready}, 64'h1);
        sel = 2'd1; step();
        chk("bp_in_ready_full", {63'h0, in_ready}, 64'h0);
        chk("bp_y_holds_a", {32'h0, y}, 64'hAAAA_AAAA);
        // Held valid while FULL must not be accepted.
        sel = 2'd2; step();
        in_valid = 1'b0;
        chk("bp_y_still_a", {32'h0, y}, 64'hAAAA_AAAA);
        chk("bp_still_full", {63'h0, in_ready}, 64'h0);
        out_ready = 1'b1; step();
        chk("bp_y_b", {32'h0, y}, 64'hBBBB_BBBB);
        chk("bp_in_ready_back", {63'h0, in_ready}, 64'h1);
        step();
        chk("bp_empty", {63'h0, out_valid}, 64'h0);
        chk("bp_pops", 64'(pops - p0), 64'd2);

        // ---- 5. flush while FULL with a new valid presented ----
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 2'd0; step();
        sel = 2'd1; step();
        chk("fl_full", {63'h0, in_ready}, 64'h0);
        flush = 1'b1; sel = 2'd2; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", {63'h0, out_valid}, 64'h0);
        chk("fl_in_ready", {63'h0, in_ready}, 64'h1);
        out_ready = 1'b1;
        p0 = pops;
        repeat (3) step();
        chk("fl_nothing_leaks", 64'(pops - p0), 64'd0);
        in_valid = 1'b1; sel = 2'd3; step();
        in_valid = 1'b0;
        chk("fl_resume_y", {32'h0, y}, 64'h3333_3333);
        step();

        // ---- flush + pop in the same cycle ----
        p0 = pops;
        in_valid = 1'b1; sel = 2'd0; step();
        in_valid = 1'b0; flush = 1'b1; step();
        flush = 1'b0;
        chk("flpop_pops", 64'(pops - p0), 64'd1);
        chk("flpop_empty", {63'h0, out_valid}, 64'h0);

        // ---- reset asserted mid-transfer ----
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 2'd1; step();
        in_valid = 1'b0;
        chk("mid_loaded", {63'h0, out_valid}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("mid_rst_y", {32'h0, y}, 64'h0);
        chk("mid_rst_in_ready", {63'h0, in_ready}, 64'h1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mid_after_release", {63'h0, out_valid}, 64'h0);

        // ---- 4/6. select table on NUM_SRC=3 instance ----
        for (int i = 0; i < 7; i++) begin
            in3_valid = 1'b1; sel3 = tbl[i].sel;
            step();
            chk("tbl_valid", {63'h0, out3_valid}, 64'h1);
            chk("tbl_y", {32'h0, y3}, {32'h0, tbl[i].y});
            chk("tbl_sel_err", {63'h0, sel3_err}, {63'h0, tbl[i].err});
`ifdef EX_OPMUX_PARITY_EN
            chk("tbl_y_par", {63'h0, y3_par}, {63'h0, tbl[i].par});
`endif
        end
        in3_valid = 1'b0;
        step();
        chk("tbl_drained", {63'h0, out3_valid}, 64'h0);

        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
